// File: rtl/a2f_pkt_arbiter_pkg.sv
// Shared definitions for the A2F FTDI read-path arbiter: FSM encoding, grant
// codes and the IQ-pair to FTDI-word packing rule.
package a2f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIFO_PKT = 2'd1,
        ST_CPU_PKT  = 2'd2
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_FIFO = 2'b01;
    localparam logic [1:0] GRANT_CPU  = 2'b10;

    localparam int IQ_HALF_WIDTH = 12;

    // Q sits in the upper half of the pair, I in the lower half; unused bits stay 0.
    function automatic logic [31:0] iq_pack(input logic [23:0] iq, input int qstart);
        logic [31:0] i_word;
        logic [31:0] q_word;
        i_word = 32'(iq[IQ_HALF_WIDTH-1:0]);
        q_word = 32'(iq[2*IQ_HALF_WIDTH-1:IQ_HALF_WIDTH]);
        return i_word | (q_word << qstart);
    endfunction

endpackage

// File: rtl/a2f_pkt_arbiter_if.sv
// Bundle of sample-FIFO, ECPU and FTDI read-side signals around the arbiter.
// The arbiter uses the slave view; the surrounding logic drives the master view.
interface a2f_pkt_arbiter_if #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int IQ_PAIR_WIDTH = 24
);
    logic [IQ_PAIR_WIDTH-1:0] fifo_data_i;
    logic                     fifo_empty_i;
    logic                     fifo_enough_i;
    logic                     fifo_re_o;
    logic [FT_DATA_WIDTH-1:0] cpu_data_i;
    logic                     cpu_empty_i;
    logic                     cpu_re_o;
    logic                     re_i;
    logic [FT_DATA_WIDTH-1:0] data_o;
    logic                     empty_o;
    logic                     enough_o;
    logic [1:0]               grant_o;
    logic                     pkt_done_o;

    modport slave (
        input  fifo_data_i, fifo_empty_i, fifo_enough_i,
        input  cpu_data_i, cpu_empty_i, re_i,
        output fifo_re_o, cpu_re_o, data_o, empty_o, enough_o, grant_o, pkt_done_o
    );

    modport master (
        output fifo_data_i, fifo_empty_i, fifo_enough_i,
        output cpu_data_i, cpu_empty_i, re_i,
        input  fifo_re_o, cpu_re_o, data_o, empty_o, enough_o, grant_o, pkt_done_o
    );
endinterface

// File: rtl/a2f_pkt_arbiter_iq_pack.sv
// Combinational 24-bit IQ pair to 32-bit FTDI word packer, shared by FTDI paths.
module a2f_iq_pack
    import a2f_pkg::*;
#(
    parameter int QSTART_BIT_INDEX = 16
) (
    input  logic [23:0] iq_i,
    output logic [31:0] word_o
);

    assign word_o = iq_pack(iq_i, QSTART_BIT_INDEX);

endmodule

// File: rtl/a2f_pkt_arbiter.sv
// Packet-granular arbiter sharing the FTDI read port between the IQ sample FIFO
// and the ECPU message source; a grant is held for a whole packet.
//
// state       | meaning
// ST_IDLE     | no grant; arbitrate every cycle, grant applies next cycle
// ST_FIFO_PKT | sample FIFO owns the port until PKT_WORDS words accepted
// ST_CPU_PKT  | ECPU owns the port until PKT_WORDS words accepted
module a2f_pkt_arbiter
    import a2f_pkg::*;
#(
    parameter int FT_DATA_WIDTH    = 32,
    parameter int IQ_PAIR_WIDTH    = 24,
    parameter int QSTART_BIT_INDEX = 16,
    parameter int PKT_WORDS        = 256,
    parameter int CPU_MAX_BURST    = 4
) (
    input  logic         clk_i,
    input  logic         reset_i,
    a2f_pkt_arbiter_if.slave bus
);

    localparam int CNT_W   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int BURST_W = $clog2(CPU_MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PKT_WORDS - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CPU_MAX_BURST);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
    logic [BURST_W-1:0]       cpu_burst_q, cpu_burst_d;

    logic                     src_empty;
    logic                     accept;
    logic                     last_word;
    logic                     cpu_wins;
    logic                     fifo_wins;
    logic [IQ_PAIR_WIDTH-1:0] iq_sample;
    logic [FT_DATA_WIDTH-1:0] fifo_word;

    assign iq_sample = bus.fifo_data_i;

    a2f_iq_pack #(
        .QSTART_BIT_INDEX(QSTART_BIT_INDEX)
    ) u_iq_pack (
        .iq_i  (iq_sample),
        .word_o(fifo_word)
    );

    assign src_empty = (state_q == ST_FIFO_PKT) ? bus.fifo_empty_i :
                       (state_q == ST_CPU_PKT)  ? bus.cpu_empty_i  : 1'b1;
    assign accept    = (state_q != ST_IDLE) & bus.re_i & ~src_empty;
    assign last_word = accept & (word_cnt_q == CNT_LAST);

    // CPU may only starve the FIFO for CPU_MAX_BURST packets while the FIFO has a full packet.
    assign cpu_wins  = ~bus.cpu_empty_i & ((cpu_burst_q < BURST_MAX) | ~bus.fifo_enough_i);
    assign fifo_wins = ~cpu_wins & bus.fifo_enough_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            cpu_burst_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            cpu_burst_q <= cpu_burst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        cpu_burst_d = cpu_burst_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_wins) begin
                    state_d = ST_CPU_PKT;
                    if (cpu_burst_q < BURST_MAX) begin
                        cpu_burst_d = cpu_burst_q + 1'b1;
                    end
                end else if (fifo_wins) begin
                    state_d     = ST_FIFO_PKT;
                    cpu_burst_d = '0;
                end
            end
            ST_FIFO_PKT, ST_CPU_PKT: begin
                if (last_word) begin
                    word_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (accept) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.fifo_re_o  = 1'b0;
        bus.cpu_re_o   = 1'b0;
        bus.data_o     = '0;
        bus.empty_o    = 1'b1;
        bus.grant_o    = GRANT_NONE;
        bus.enough_o   = bus.fifo_enough_i | ~bus.cpu_empty_i;
        bus.pkt_done_o = last_word;
        case (state_q)
            ST_FIFO_PKT: begin
                bus.fifo_re_o = accept;
                bus.data_o    = fifo_word;
                bus.empty_o   = src_empty;
                bus.grant_o   = GRANT_FIFO;
                bus.enough_o  = ~src_empty;
            end
            ST_CPU_PKT: begin
                bus.cpu_re_o  = accept;
                bus.data_o    = bus.cpu_data_i;
                bus.empty_o   = src_empty;
                bus.grant_o   = GRANT_CPU;
                bus.enough_o  = ~src_empty;
            end
            default: ;
        endcase
    end

endmodule
